// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. It stalls the pipeline while it iterates
// and writes the 64-bit result to HI/LO with a one-cycle strobe.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state  | meaning
  // IDLE   | waiting for start; HI/LO hold the last delivered result
  // BUSY   | one shift-add / shift-subtract step per edge, counter 0..WIDTH-1
  // FINISH | sign correction; HI/LO and done are loaded at the edge leaving this state
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FINISH} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // Divide: acc = {partial remainder, dividend/quotient}; the subtract is WIDTH+1 bits wide.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_qbit  = ~div_diff[WIDTH];
  assign div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quot_fix  = div0_q ? {WIDTH{1'b1}} : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d   = S_BUSY;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (b == '0);
          opb_d     = b_mag;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
          else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign stall   = ((state_q == S_IDLE) && start && !flush) || (state_q == S_BUSY);
  assign done    = done_q;
  assign hilo_we = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, stall window, arithmetic corner cases,
// flush, ignored start and asynchronous reset, all against hand-computed values.
module tb_muldiv_seq;
  logic        clk, rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done, hilo_we;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hilo_we(hilo_we), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE and follow it to its done pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int steps, stall_cnt;
    start = 1'b1; op = o; a = av; b = bv;
    #1;
    stall_cnt = stall ? 1 : 0;
    step();
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    steps = 0;
    while (!done && steps < 40) begin
      if (stall) stall_cnt++;
      step();
      steps++;
    end
    check({tag, " latency"}, 64'(steps), 64'd33);
    check({tag, " stall cycles"}, 64'(stall_cnt), 64'd33);
    check({tag, " hilo_we"}, 64'(hilo_we), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    step();
    check({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    step();
    check("reset busy", 64'(busy), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hilo_we", 64'(hilo_we), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst = 1'b1;
    step();

    run_op("mult -3*7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -5*-6", MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'd30);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div 5/0", DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("divu big/0", DIVU, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div -5/0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // flush while BUSY at counter 10
    start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy -> idle", 64'(busy), 64'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (hilo_we) pulses++;
      step();
    end
    check("flush busy no strobe", 64'(pulses), 64'd0);
    check("flush busy hi held", 64'(hi), 64'(32'hFFFF_FFFB));
    check("flush busy lo held", 64'(lo), 64'(32'hFFFF_FFFF));

    // flush while FINISH
    start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    repeat (32) step();
    check("in finish busy", 64'(busy), 64'd1);
    check("in finish stall", 64'(stall), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush finish -> idle", 64'(busy), 64'd0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (hilo_we) pulses++;
      step();
    end
    check("flush finish no strobe", 64'(pulses), 64'd0);
    check("flush finish hi held", 64'(hi), 64'(32'hFFFF_FFFB));
    check("flush finish lo held", 64'(lo), 64'(32'hFFFF_FFFF));

    // start together with flush in IDLE
    start = 1'b1; flush = 1'b1; op = MULTU; a = 32'd2; b = 32'd2;
    #1;
    check("start+flush stall", 64'(stall), 64'd0);
    step();
    check("start+flush stays idle", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;
    step();

    // start held during BUSY is ignored
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    step();
    op = MULTU; a = 32'd2; b = 32'd3;
    repeat (20) step();
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) pulses++;
      step();
    end
    check("start in busy one done", 64'(pulses), 64'd1);
    check("start in busy hi", 64'(hi), 64'd2);
    check("start in busy lo", 64'(lo), 64'd14);
    check("start in busy idle after", 64'(busy), 64'd0);

    // asynchronous reset mid-BUSY
    start = 1'b1; op = MULT; a = 32'd11; b = 32'd13;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset stall", 64'(stall), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset hi", 64'(hi), 64'd0);
    check("async reset lo", 64'(lo), 64'd0);
    step();
    rst = 1'b1;
    step();
    run_op("multu 3*5 after reset", MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    // back-to-back: start in the cycle right after the done pulse cycle
    run_op("divu 7/7 back-to-back", DIVU, 32'd7, 32'd7, 32'd0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
